// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the single-port 1RW SRAM host controller.
//   - FSM state encodings (IDLE, WRITE, READ, CAPTURE)
//   - SRAM control pin bundle and its inactive value
//   - Read-wait counter width
package sram_ctrl_pkg;

  localparam int unsigned ST_W      = 2;
  localparam int unsigned RD_WAIT_W = 4;

  localparam logic [ST_W-1:0] ST_IDLE    = 2'd0;
  localparam logic [ST_W-1:0] ST_WRITE   = 2'd1;
  localparam logic [ST_W-1:0] ST_READ    = 2'd2;
  localparam logic [ST_W-1:0] ST_CAPTURE = 2'd3;

  // Active-low SRAM control pins, in macro pin order.
  typedef struct packed {
    logic csb;
    logic web;
    logic oeb;
  } sram_pins_t;

  localparam sram_pins_t PINS_INACTIVE = sram_pins_t'(3'b111);
  localparam sram_pins_t PINS_WRITE    = sram_pins_t'(3'b001);
  localparam sram_pins_t PINS_READ     = sram_pins_t'(3'b010);

endpackage

// File: rtl/sram_data_iobuf.sv
// Tri-state driver for the shared SRAM DATA bus.
// Ports:
//   i_en    - drive enable (registered by the caller)
//   i_dout  - value driven onto the pad when enabled
//   o_din   - pad value as seen by the host (always connected)
//   io_pad  - bidirectional SRAM DATA pins
module sram_data_iobuf #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  i_en,
  input  logic [DATA_WIDTH-1:0] i_dout,
  output logic [DATA_WIDTH-1:0] o_din,
  inout  wire  [DATA_WIDTH-1:0] io_pad
);

  assign io_pad = i_en ? i_dout : {DATA_WIDTH{1'bz}};
  assign o_din  = io_pad;

endmodule

// File: rtl/sram_1rw_host_ctrl.sv
// Host-side controller for a single-port 1RW OpenRAM macro.
// Takes one read/write request per valid/ready handshake, sequences the
// active-low CSb/WEb/OEb pins, owns the host side of DATA, and returns read
// data on a one-cycle rsp_valid strobe.
// Ports:
//   clk, rstb                 - clock shared with the macro, async active-low reset
//   req_valid/ready/we/addr/wdata - request channel (req_ready is combinational)
//   rsp_valid, rsp_rdata      - read response strobe and captured data
//   sram_addr/csb/web/oeb     - registered macro control pins
//   sram_data                 - macro DATA bus, driven only during a write
module sram_1rw_host_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned RD_WAIT    = 0
) (
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic                  sram_oeb,
  inout  wire  [DATA_WIDTH-1:0] sram_data
);

  logic [ST_W-1:0]       r_state;
  logic [ST_W-1:0]       w_state_nxt;
  sram_pins_t            r_pins;
  sram_pins_t            w_pins_nxt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] w_wdata_nxt;
  logic                  r_drv_en;
  logic                  w_drv_en_nxt;
  logic                  r_rsp_valid;
  logic                  w_rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic [DATA_WIDTH-1:0] w_rsp_rdata_nxt;
  logic [RD_WAIT_W-1:0]  r_cnt;
  logic [RD_WAIT_W-1:0]  w_cnt_nxt;
  logic [DATA_WIDTH-1:0] w_din;

  // DATA pad isolation; the enable is a registered flag so the bus only
  // turns around on clock edges.
  sram_data_iobuf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_iobuf (
    .i_en  (r_drv_en),
    .i_dout(r_wdata),
    .o_din (w_din),
    .io_pad(sram_data)
  );

  // State and registered pins.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state     <= ST_IDLE;
      r_pins      <= PINS_INACTIVE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_drv_en    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pins      <= w_pins_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_drv_en    <= w_drv_en_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  // Next-state and next-pin logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_pins_nxt      = r_pins;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_drv_en_nxt    = r_drv_en;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_cnt_nxt       = r_cnt;

    case (r_state)
      ST_IDLE: begin
        w_pins_nxt   = PINS_INACTIVE;
        w_drv_en_nxt = 1'b0;
        if (req_valid) begin
          w_addr_nxt  = req_addr;
          w_wdata_nxt = req_wdata;
          if (req_we) begin
            w_state_nxt  = ST_WRITE;
            w_pins_nxt   = PINS_WRITE;
            w_drv_en_nxt = 1'b1;
          end else begin
            w_state_nxt  = ST_READ;
            w_pins_nxt   = PINS_READ;
          end
        end
      end

      // Macro samples the write at this edge; release the bus immediately.
      ST_WRITE: begin
        w_state_nxt  = ST_IDLE;
        w_pins_nxt   = PINS_INACTIVE;
        w_drv_en_nxt = 1'b0;
      end

      // Macro launches the read at this edge; pins stay held so DATA stays driven.
      ST_READ: begin
        w_state_nxt = ST_CAPTURE;
        w_cnt_nxt   = RD_WAIT_W'(RD_WAIT);
      end

      ST_CAPTURE: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - RD_WAIT_W'(1);
        end else begin
          w_rsp_rdata_nxt = w_din;
          w_rsp_valid_nxt = 1'b1;
          w_pins_nxt      = PINS_INACTIVE;
          w_state_nxt     = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt  = ST_IDLE;
        w_pins_nxt   = PINS_INACTIVE;
        w_drv_en_nxt = 1'b0;
        w_cnt_nxt    = '0;
      end
    endcase
  end

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign sram_addr = r_addr;
  assign sram_csb  = r_pins.csb;
  assign sram_web  = r_pins.web;
  assign sram_oeb  = r_pins.oeb;

endmodule
